// File: rtl/id_stage.sv
// Decode stage: logic/immediate ops with register-file reads and EX/MEM forwarding, one-cycle output register.
// Latency 1 cycle inst_i -> ex_*; stall holds the register, flush (wins over stall) loads a bubble.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  output logic        reg1_read_o,
  output logic        reg2_read_o,
  output logic [4:0]  reg1_addr_o,
  output logic [4:0]  reg2_addr_o,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  output logic [7:0]  ex_aluop_o,
  output logic [2:0]  ex_alusel_o,
  output logic [31:0] ex_reg1_o,
  output logic [31:0] ex_reg2_o,
  output logic [4:0]  ex_wd_o,
  output logic        ex_wreg_o,
  output logic        ex_valid_o,
  output logic        illegal_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALUOP_NOP = 8'h00;
  localparam logic [7:0] ALUOP_AND = 8'h24;
  localparam logic [7:0] ALUOP_OR  = 8'h25;
  localparam logic [7:0] ALUOP_XOR = 8'h26;
  localparam logic [7:0] ALUOP_NOR = 8'h27;

  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  logic        dec_ok;
  logic [7:0]  dec_aluop;
  logic [2:0]  dec_alusel;
  logic        dec_rd1;
  logic        dec_rd2;
  logic [31:0] dec_imm;
  logic [4:0]  dec_wd;
  logic        dec_illegal;

  always_comb begin
    dec_ok     = 1'b0;
    dec_aluop  = ALUOP_NOP;
    dec_alusel = ALUSEL_NOP;
    dec_rd1    = 1'b0;
    dec_rd2    = 1'b0;
    dec_imm    = 32'h0;
    dec_wd     = 5'd0;
    if (inst_valid_i) begin
      case (op)
        OP_SPECIAL: begin
          if (sa == 5'd0) begin
            case (funct)
              FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                dec_ok     = 1'b1;
                dec_alusel = ALUSEL_LOGIC;
                dec_rd1    = 1'b1;
                dec_rd2    = 1'b1;
                dec_wd     = rd;
                case (funct)
                  FN_AND:  dec_aluop = ALUOP_AND;
                  FN_OR:   dec_aluop = ALUOP_OR;
                  FN_XOR:  dec_aluop = ALUOP_XOR;
                  default: dec_aluop = ALUOP_NOR;
                endcase
              end
              default: dec_ok = 1'b0;
            endcase
          end
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          dec_ok     = 1'b1;
          dec_alusel = ALUSEL_LOGIC;
          dec_rd1    = 1'b1;
          dec_imm    = {16'h0, imm};
          dec_wd     = rt;
          case (op)
            OP_ANDI: dec_aluop = ALUOP_AND;
            OP_ORI:  dec_aluop = ALUOP_OR;
            default: dec_aluop = ALUOP_XOR;
          endcase
        end
        OP_LUI: begin
          dec_ok     = 1'b1;
          dec_aluop  = ALUOP_OR;
          dec_alusel = ALUSEL_LOGIC;
          dec_imm    = {imm, 16'h0};
          dec_wd     = rt;
        end
        default: dec_ok = 1'b0;
      endcase
    end
  end

  // An all-zero word is the canonical bubble, not an illegal encoding.
  assign dec_illegal = inst_valid_i && !dec_ok && (inst_i != 32'h0);

  assign reg1_read_o = dec_rd1;
  assign reg2_read_o = dec_rd2;
  assign reg1_addr_o = dec_rd1 ? rs : 5'd0;
  assign reg2_addr_o = dec_rd2 ? rt : 5'd0;

  // Port 1 never carries an immediate; for port 2 dec_imm is the non-read value.
  function automatic logic [31:0] pick_operand(
    input logic        en,
    input logic [4:0]  addr,
    input logic [31:0] alt,
    input logic [31:0] rf_data,
    input logic        ex_we,
    input logic [4:0]  ex_wd,
    input logic [31:0] ex_wdata,
    input logic        mem_we,
    input logic [4:0]  mem_wd,
    input logic [31:0] mem_wdata
  );
    logic [31:0] val;
    if (!en)                           val = alt;
    else if (addr == 5'd0)             val = 32'h0;
    else if (ex_we && ex_wd == addr)   val = ex_wdata;
    else if (mem_we && mem_wd == addr) val = mem_wdata;
    else                               val = rf_data;
    return val;
  endfunction

  logic [31:0] opnd1;
  logic [31:0] opnd2;

  assign opnd1 = pick_operand(dec_rd1, reg1_addr_o, 32'h0, reg1_data_i,
                              ex_wreg_i, ex_wd_i, ex_wdata_i,
                              mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign opnd2 = pick_operand(dec_rd2, reg2_addr_o, dec_imm, reg2_data_i,
                              ex_wreg_i, ex_wd_i, ex_wdata_i,
                              mem_wreg_i, mem_wd_i, mem_wdata_i);

  logic [7:0]  aluop_d,   aluop_q;
  logic [2:0]  alusel_d,  alusel_q;
  logic [31:0] reg1_d,    reg1_q;
  logic [31:0] reg2_d,    reg2_q;
  logic [4:0]  wd_d,      wd_q;
  logic        wreg_d,    wreg_q;
  logic        valid_d,   valid_q;
  logic        illegal_d, illegal_q;

  // illegal is a one-shot: it is never held across a stall.
  always_comb begin
    aluop_d   = aluop_q;
    alusel_d  = alusel_q;
    reg1_d    = reg1_q;
    reg2_d    = reg2_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    valid_d   = valid_q;
    illegal_d = 1'b0;
    if (flush) begin
      aluop_d  = ALUOP_NOP;
      alusel_d = ALUSEL_NOP;
      reg1_d   = 32'h0;
      reg2_d   = 32'h0;
      wd_d     = 5'd0;
      wreg_d   = 1'b0;
      valid_d  = 1'b0;
    end else if (!stall) begin
      aluop_d   = dec_aluop;
      alusel_d  = dec_alusel;
      reg1_d    = opnd1;
      reg2_d    = opnd2;
      wd_d      = dec_wd;
      wreg_d    = dec_ok && (dec_wd != 5'd0);
      valid_d   = dec_ok;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_q   <= ALUOP_NOP;
      alusel_q  <= ALUSEL_NOP;
      reg1_q    <= 32'h0;
      reg2_q    <= 32'h0;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      aluop_q   <= aluop_d;
      alusel_q  <= alusel_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_aluop_o  = aluop_q;
  assign ex_alusel_o = alusel_q;
  assign ex_reg1_o   = reg1_q;
  assign ex_reg2_o   = reg2_q;
  assign ex_wd_o     = wd_q;
  assign ex_wreg_o   = wreg_q;
  assign ex_valid_o  = valid_q;
  assign illegal_o   = illegal_q;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001: Parameters: none; opcode, funct, aluop and alusel encodings are fixed by this document.
REQ-002: clk  in  1  rising-edge clock.
REQ-003: rst  in  1  reset, synchronous, active-high.
REQ-004: stall  in  1  hold the output register.
REQ-005: flush  in  1  load a bubble into the output register.
REQ-006: inst_i  in  32  instruction word.
REQ-007: inst_valid_i  in  1  inst_i holds a real instruction.
REQ-008: reg1_read_o, reg2_read_o  out  1 each  register-file read enables (combinational).
REQ-009: reg1_addr_o, reg2_addr_o  out  5 each  register-file read addresses (combinational).
REQ-010: reg1_data_i, reg2_data_i  in  32 each  register-file read data, same cycle.
REQ-011: ex_wreg_i, ex_wd_i, ex_wdata_i  in  1/5/32  execute-stage result, for forwarding.
REQ-012: mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/5/32  memory-stage result, for forwarding.
REQ-013: ex_aluop_o  out  8  registered ALU operation.
REQ-014: ex_alusel_o  out  3  registered result class.
REQ-015: ex_reg1_o, ex_reg2_o  out  32 each  registered operands.
REQ-016: ex_wd_o, ex_wreg_o  out  5/1  registered destination and write enable.
REQ-017: ex_valid_o  out  1  registered slot valid.
REQ-018: illegal_o  out  1  registered one-cycle flag for an undecodable valid instruction.

Function
REQ-019: Encodings SHALL be: aluop NOP 8'h00, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27; alusel NOP 3'b000, LOGIC 3'b001.
REQ-020: Field names: op=inst[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], funct=[5:0], imm=[15:0].
REQ-021: op 001100 (ANDI), 001101 (ORI) and 001110 (XORI) SHALL map to aluop AND/OR/XOR, alusel LOGIC; read rs on port 1; port 2 not read; operand 2 = {16'h0, imm}; wd=rt; wreg=1.
REQ-022: op 001111 (LUI) SHALL map to aluop OR, alusel LOGIC; no reads; operand 1 = 0; operand 2 = {imm, 16'h0}; wd=rt; wreg=1.
REQ-023: op 000000 with sa=0 and funct 100100/100101/100110/100111 SHALL map to AND/OR/XOR/NOR, alusel LOGIC; read rs and rt; wd=rd; wreg=1.
REQ-024: inst_i==32'h0 SHALL decode as a bubble with illegal_o=0.
REQ-025: Any other word with inst_valid_i=1 SHALL decode as a bubble with illegal_o=1.
REQ-026: inst_valid_i=0 SHALL decode as a bubble with illegal_o=0 and both read enables 0.
REQ-027: A bubble SHALL have aluop 0, alusel 0, operands 0, wd 0, wreg 0 and valid 0.
REQ-028: Read enables and addresses SHALL be driven combinationally from inst_i; an address is 0 when its enable is 0.
REQ-029: Operand selection priority per port SHALL be:
  (a) read disabled -> immediate or 0 (REQ-021/022);
  (b) address 0 -> 32'h0;
  (c) ex_wreg_i and ex_wd_i==addr -> ex_wdata_i;
  (d) mem_wreg_i and mem_wd_i==addr -> mem_wdata_i;
  (e) otherwise reg*_data_i.
REQ-030: A decoded destination of 0 SHALL force wreg to 0; the slot stays valid.
REQ-031: On each clock, output register priority SHALL be rst > flush > stall > load.
  - flush loads a bubble.
  - stall holds all outputs, except illegal_o, which is 0.
  - load captures the decode with valid=1 for decoded instructions.
REQ-032: Latency SHALL be one cycle from inst_i to ex_* outputs.
REQ-033: flush and stall asserted together SHALL load a bubble.

Reset
REQ-034: With rst=1 at a clock edge, every registered output SHALL become 0 on that edge, overriding stall and flush, including mid-stall.
REQ-035: Combinational read outputs SHALL follow inst_i regardless of rst.

Verification
REQ-036: ORI r1,r0,0x1100 (34011100) with inst_valid_i=1 -> next cycle: aluop 25, alusel 1, reg1 0, reg2 00001100, wd 1, wreg 1, valid 1.
REQ-037: OR r3,r1,r2 (00221825) with ex_wd_i=1, ex_wdata_i=AAAA0000, mem_wd_i=2, mem_wdata_i=00005555, and regfile data=FFFFFFFF -> reg1 AAAA0000, reg2 00005555, wd 3.
REQ-038: OR r3,r1,r1 with ex and mem both writing r1 (values 1, 2) -> reg1=reg2=1, showing ex priority.
REQ-039: LUI r5,0x1234 (3C051234) -> reg1_read_o=0, reg2 12340000, aluop 25; then with stall=1 for 3 cycles and a new inst -> outputs unchanged; then flush=1 with stall=1 -> bubble.
REQ-040: Word FC000000 with inst_valid_i=1 -> illegal_o=1 for one cycle and a bubble; then inst 00000000 -> illegal_o=0.
REQ-041: ORI r0,r1,5 -> wreg 0, valid 1; then rst=1 during stall -> all outputs 0 on the next edge.
